// File: rtl/cbm2_keyboard.sv
// rtl/cbm2_keyboard.sv - CBM-II keyboard matrix emulator (ps2_key -> 16x6 matrix), optional CBM2_SHIFTLOCK_EN
module cbm2_keyboard #(
  parameter int unsigned HOLD_CYCLES = 655360
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] col_n,
  output logic [5:0]  row_n,
  output logic        shiftlock
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_LOOKUP = 2'd1;
  localparam logic [1:0]  ST_APPLY  = 2'd2;
  localparam logic [19:0] HOLD_LOAD = 20'(HOLD_CYCLES);

  logic [1:0]        state_q, state_d;
  logic              last_tgl_q, last_tgl_d;
  logic              press_q, press_d;
  logic [8:0]        addr_q, addr_d;
  logic [7:0]        rom_q;
  logic [15:0][5:0]  key_q, key_d;
  logic [3:0]        hold_col_q, hold_col_d;
  logic [2:0]        hold_row_q, hold_row_d;
  logic [19:0]       hold_cnt_q, hold_cnt_d;
  logic              rel_pending_q, rel_pending_d;
  logic [5:0]        row_n_q, row_n_d;

  logic              map_ok;
  logic [3:0]        map_col;
  logic [2:0]        map_row;

  // Keymap contents: {valid, row[2:0], col[3:0]} indexed by {E0, scancode}
  function automatic logic [7:0] keymap(input logic [8:0] addr);
    case (addr)
      9'h01C:  keymap = 8'h92;  // A       -> col 2, row 1
      9'h012:  keymap = 8'hC8;  // L-Shift -> col 8, row 4
      9'h058:  keymap = 8'hB1;  // Caps    -> col 1, row 3 (Shift-Lock)
      9'h029:  keymap = 8'h84;  // Space   -> col 4, row 0
      default: keymap = 8'h00;
    endcase
  endfunction

  assign map_row = rom_q[6:4];
  assign map_col = rom_q[3:0];
  assign map_ok  = rom_q[7] && (map_row <= 3'd5);

`ifdef CBM2_SHIFTLOCK_EN
  localparam logic [8:0] SL_ADDR = 9'h058;
  logic shiftlock_q, shiftlock_d;
  logic sl_hit;
  assign sl_hit    = (addr_q == SL_ADDR);
  assign shiftlock = shiftlock_q;
`else
  assign shiftlock = 1'b0;
`endif

  // Synchronous keymap ROM read; data is valid the cycle after the address latches
  always_ff @(posedge clk_sys) begin
    rom_q <= keymap(addr_q);
  end

  // Event FSM, hold-slot countdown and matrix update (expiry first, then the event)
  always_comb begin
    state_d       = state_q;
    last_tgl_d    = last_tgl_q;
    press_d       = press_q;
    addr_d        = addr_q;
    key_d         = key_q;
    hold_col_d    = hold_col_q;
    hold_row_d    = hold_row_q;
    hold_cnt_d    = hold_cnt_q;
    rel_pending_d = rel_pending_q;
`ifdef CBM2_SHIFTLOCK_EN
    shiftlock_d   = shiftlock_q;
`endif

    if (hold_cnt_q != 20'd0) begin
      hold_cnt_d = hold_cnt_q - 20'd1;
      if (hold_cnt_q == 20'd1 && rel_pending_q) begin
        key_d[hold_col_q][hold_row_q] = 1'b0;
        rel_pending_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (ps2_key[10] != last_tgl_q) begin
          last_tgl_d = ps2_key[10];
          press_d    = ps2_key[9];
          addr_d     = ps2_key[8:0];
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: state_d = ST_APPLY;
      ST_APPLY: begin
        state_d = ST_IDLE;
`ifdef CBM2_SHIFTLOCK_EN
        if (sl_hit) begin
          if (press_q) begin
            shiftlock_d = ~shiftlock_q;
            key_d[1][3] = ~shiftlock_q;
          end
        end else
`endif
        if (map_ok) begin
          if (press_q) begin
            if (rel_pending_d) key_d[hold_col_q][hold_row_q] = 1'b0;
            key_d[map_col][map_row] = 1'b1;
            hold_col_d    = map_col;
            hold_row_d    = map_row;
            hold_cnt_d    = HOLD_LOAD;
            rel_pending_d = 1'b0;
          end else if (map_col == hold_col_q && map_row == hold_row_q && hold_cnt_d != 20'd0) begin
            rel_pending_d = 1'b1;
          end else begin
            key_d[map_col][map_row] = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Row return: OR of every selected column, inverted to active low
  always_comb begin
    logic [5:0] acc;
    acc = 6'd0;
    for (int c = 0; c < 16; c++) begin
      if (!col_n[c]) acc = acc | key_q[c];
    end
    row_n_d = ~acc;
  end

  // State registers; reset resyncs the toggle so no phantom event fires
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_tgl_q    <= ps2_key[10];
      press_q       <= 1'b0;
      addr_q        <= 9'd0;
      key_q         <= '0;
      hold_col_q    <= 4'd0;
      hold_row_q    <= 3'd0;
      hold_cnt_q    <= 20'd0;
      rel_pending_q <= 1'b0;
      row_n_q       <= 6'h3F;
`ifdef CBM2_SHIFTLOCK_EN
      shiftlock_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      last_tgl_q    <= last_tgl_d;
      press_q       <= press_d;
      addr_q        <= addr_d;
      key_q         <= key_d;
      hold_col_q    <= hold_col_d;
      hold_row_q    <= hold_row_d;
      hold_cnt_q    <= hold_cnt_d;
      rel_pending_q <= rel_pending_d;
      row_n_q       <= row_n_d;
`ifdef CBM2_SHIFTLOCK_EN
      shiftlock_q   <= shiftlock_d;
`endif
    end
  end

  assign row_n = row_n_q;

endmodule

// File: tb/tb_cbm2_keyboard.sv
// tb/tb_cbm2_keyboard.sv - self-checking bench for cbm2_keyboard
module tb_cbm2_keyboard;

  localparam int H = 1000;
`ifdef CBM2_SHIFTLOCK_EN
  localparam bit SL_EN = 1'b1;
`else
  localparam bit SL_EN = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [10:0] ps2_key = 11'h400;
  logic [15:0] col_n   = 16'hFFFF;
  logic [5:0]  row_n;
  logic        shiftlock;

  cbm2_keyboard #(.HOLD_CYCLES(H)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_key   (ps2_key),
    .col_n     (col_n),
    .row_n     (row_n),
    .shiftlock (shiftlock)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit tgl = 1'b1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic chk_row(input string name, input logic [5:0] exp);
    checks++;
    if (row_n !== exp) begin
      failures++;
      $display("FAIL %s: row_n=%02h expected %02h (cycle %0d)", name, row_n, exp, cyc);
    end
  endtask

  task automatic chk_sl(input string name, input logic exp);
    checks++;
    if (shiftlock !== exp) begin
      failures++;
      $display("FAIL %s: shiftlock=%0b expected %0b (cycle %0d)", name, shiftlock, exp, cyc);
    end
  endtask

  task automatic send(input logic [8:0] code, input bit press);
    tgl = ~tgl;
    ps2_key = {tgl, press, code};
  endtask

  // Reference model: pressed-key set plus one hold slot with an absolute deadline
  bit mk[16][6];
  int m_hcol, m_hrow, m_hexp;
  bit m_rel, m_sl;

  task automatic m_reset();
    for (int c = 0; c < 16; c++) for (int r = 0; r < 6; r++) mk[c][r] = 1'b0;
    m_hcol = 0; m_hrow = 0; m_hexp = 0; m_rel = 1'b0; m_sl = 1'b0;
  endtask

  task automatic m_lookup(input logic [8:0] code, output bit ok, output int c, output int r);
    ok = 1'b1; c = 0; r = 0;
    case (code)
      9'h01C:  begin c = 2; r = 1; end
      9'h012:  begin c = 8; r = 4; end
      9'h058:  begin c = 1; r = 3; end
      9'h029:  begin c = 4; r = 0; end
      default: ok = 1'b0;
    endcase
  endtask

  task automatic m_advance(input int e);
    if (m_rel && e >= m_hexp) begin
      mk[m_hcol][m_hrow] = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic m_event(input logic [8:0] code, input bit press, input int a);
    bit ok; int c; int r;
    m_advance(a);
    m_lookup(code, ok, c, r);
    if (SL_EN && code == 9'h058) begin
      if (press) begin
        m_sl = ~m_sl;
        mk[1][3] = m_sl;
      end
    end else if (ok) begin
      if (press) begin
        if (m_rel) mk[m_hcol][m_hrow] = 1'b0;
        mk[c][r] = 1'b1;
        m_hcol = c; m_hrow = r; m_hexp = a + H; m_rel = 1'b0;
      end else if (c == m_hcol && r == m_hrow && a < m_hexp) begin
        m_rel = 1'b1;
      end else begin
        mk[c][r] = 1'b0;
      end
    end
  endtask

  function automatic logic [5:0] m_row(input logic [15:0] cols);
    logic [5:0] v;
    v = 6'h3F;
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < 6; r++)
        if (!cols[c] && mk[c][r]) v[r] = 1'b0;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    chk_row("reset_row", 6'h3F);
    chk_sl("reset_sl", 1'b0);
    reset = 1'b0;
    tick(1);
    m_reset();
  endtask

  typedef struct {
    bit          ev;
    logic [8:0]  code;
    bit          press;
    logic [15:0] col;
    int          wt;
    logic [5:0]  row;
  } vec_t;

  vec_t tbl[14];

  logic [8:0] codes[7];

  initial begin
    int d;
    tbl[0]  = '{1'b1, 9'h01C, 1'b1, 16'hFFFB, 6,    6'h3D};
    tbl[1]  = '{1'b0, 9'h000, 1'b0, 16'hFFFF, 2,    6'h3F};
    tbl[2]  = '{1'b1, 9'h029, 1'b1, 16'hFFEF, 6,    6'h3E};
    tbl[3]  = '{1'b0, 9'h000, 1'b0, 16'h0000, 2,    6'h3C};
    tbl[4]  = '{1'b1, 9'h000, 1'b1, 16'h0000, 6,    6'h3C};
    tbl[5]  = '{1'b1, 9'h11C, 1'b1, 16'hFFFB, 6,    6'h3D};
    tbl[6]  = '{1'b1, 9'h012, 1'b1, 16'hFEFF, 6,    6'h2F};
    tbl[7]  = '{1'b1, 9'h01C, 1'b0, 16'hFFFB, 6,    6'h3F};
    tbl[8]  = '{1'b0, 9'h000, 1'b0, 16'h0000, 2,    6'h2E};
    tbl[9]  = '{1'b1, 9'h029, 1'b0, 16'hFFEF, 6,    6'h3F};
    tbl[10] = '{1'b1, 9'h012, 1'b0, 16'hFEFF, 6,    6'h2F};
    tbl[11] = '{1'b0, 9'h000, 1'b0, 16'hFEFF, 1000, 6'h3F};
    tbl[12] = '{1'b1, 9'h01C, 1'b1, 16'h7FFF, 6,    6'h3F};
    tbl[13] = '{1'b0, 9'h000, 1'b0, 16'h0000, 2,    6'h3D};

    codes[0] = 9'h01C; codes[1] = 9'h012; codes[2] = 9'h058; codes[3] = 9'h029;
    codes[4] = 9'h000; codes[5] = 9'h076; codes[6] = 9'h11C;

    // Reset state and no spurious event with a steady toggle
    do_reset();
    col_n = 16'h0000;
    tick(10);
    chk_row("idle_no_event", 6'h3F);
    chk_sl("idle_sl", 1'b0);

    // Table-driven sequence
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].ev) send(tbl[i].code, tbl[i].press);
      col_n = tbl[i].col;
      tick(tbl[i].wt);
      chk_row($sformatf("tbl%0d", i), tbl[i].row);
      chk_sl($sformatf("tbl%0d_sl", i), 1'b0);
    end

    // Exact 3-cycle press latency and 1-cycle column latency
    do_reset();
    col_n = 16'hFFFB;
    tick(2);
    send(9'h01C, 1'b1);
    tick(3);
    chk_row("lat_before", 6'h3F);
    tick(1);
    chk_row("lat_after", 6'h3D);
    col_n = 16'hFFF7;
    tick(1);
    chk_row("col_lat_off", 6'h3F);
    col_n = 16'hFFFB;
    tick(1);
    chk_row("col_lat_on", 6'h3D);

    // Release deferral: key survives until press APPLY + H
    do_reset();
    col_n = 16'hFFFB;
    d = cyc;
    send(9'h01C, 1'b1);
    tick(100);
    send(9'h01C, 1'b0);
    tick(10);
    chk_row("defer_mid", 6'h3D);
    wait_cyc(d + 3 + H);
    chk_row("defer_last", 6'h3D);
    tick(1);
    chk_row("defer_clear", 6'h3F);

    // Two keys held; release after expiry is immediate
    do_reset();
    send(9'h01C, 1'b1);
    tick(5);
    send(9'h012, 1'b1);
    tick(H + 100);
    col_n = 16'hFEFB;
    tick(2);
    chk_row("two_keys", 6'h2D);
    send(9'h012, 1'b0);
    tick(3);
    chk_row("late_rel_before", 6'h2D);
    tick(1);
    chk_row("late_rel_after", 6'h3D);

    // Pending release is flushed by the next press at its APPLY edge
    do_reset();
    col_n = 16'hFFEB;
    send(9'h01C, 1'b1);
    tick(10);
    send(9'h01C, 1'b0);
    tick(20);
    chk_row("pend_held", 6'h3D);
    send(9'h029, 1'b1);
    tick(3);
    chk_row("flush_before", 6'h3D);
    tick(1);
    chk_row("flush_after", 6'h3E);
    col_n = 16'hFFEF;
    tick(1);
    chk_row("flush_space", 6'h3E);
    col_n = 16'hFFFB;
    tick(1);
    chk_row("flush_a_gone", 6'h3F);

    // Reset mid-FSM abandons the event
    do_reset();
    col_n = 16'hFFFB;
    send(9'h01C, 1'b1);
    tick(1);
    do_reset();
    col_n = 16'hFFFB;
    tick(10);
    chk_row("reset_abandon", 6'h3F);

    // Caps Lock behaviour in both build configurations
    do_reset();
    col_n = 16'hFFFD;
    d = cyc;
    send(9'h058, 1'b1);
    tick(6);
    chk_row("caps_press", 6'h37);
`ifdef CBM2_SHIFTLOCK_EN
    chk_sl("caps_sl_on", 1'b1);
    send(9'h058, 1'b0);
    tick(H + 100);
    chk_row("caps_rel_ignored", 6'h37);
    chk_sl("caps_sl_still", 1'b1);
    send(9'h058, 1'b1);
    tick(6);
    chk_row("caps_toggle_off", 6'h3F);
    chk_sl("caps_sl_off", 1'b0);
`else
    chk_sl("caps_sl_tied", 1'b0);
    send(9'h058, 1'b0);
    wait_cyc(d + 3 + H);
    chk_row("caps_hold_last", 6'h37);
    tick(1);
    chk_row("caps_hold_clear", 6'h3F);
    chk_sl("caps_sl_tied2", 1'b0);
`endif

    // Randomized events against the reference model
    do_reset();
    for (int i = 0; i < 200; i++) begin
      int w;
      logic [8:0] code;
      bit press;
      code  = codes[$urandom_range(0, 6)];
      press = ($urandom_range(0, 9) < 6);
      send(code, press);
      m_event(code, press, cyc + 3);
      if ($urandom_range(0, 1) == 0) col_n = ~(16'h1 << $urandom_range(0, 15));
      else col_n = 16'($urandom);
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(H - 100, H + 100) : $urandom_range(4, 60);
      tick(w);
      m_advance(cyc - 1);
      chk_row($sformatf("rand%0d", i), m_row(col_n));
      chk_sl($sformatf("rand%0d_sl", i), m_sl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cbm2_keyboard.md
# cbm2_keyboard

Keyboard matrix emulator for the CBM-II core. It converts MiSTer `ps2_key` events into a 16-column × 6-row key matrix, and answers TPI 2's column scan with the active-low row levels TPI 2 reads on port C. It sits directly upstream of TPI 2:

- TPI 2 port A drives columns 7:0; port B drives columns 15:8.
- Port C bits 5:0 receive `row_n`.

Short taps are stretched so the KERNAL jiffy scan always sees them.

## Interface
Parameters:
- `HOLD_CYCLES`, default 655360: minimum press duration in `clk_sys` cycles (≈20 ms at 32 MHz). Must be ≥ 1 and < 2^20.

Ports:
- `clk_sys` in 1: system clock. The block uses one clock.
- `reset` in 1: synchronous, active-high reset.
- `ps2_key` in 11: bit 10 toggles once per event; bit 9 is 1=press, 0=release; bit 8 is the extended (E0) flag; bits 7:0 are the scancode.
- `col_n` in 16: column select, active low. Bits 7:0 come from `tpi2_pao`; bits 15:8 come from `tpi2_pbo`.
- `row_n` out 6: row return, active low. It feeds `pc_in[5:0]`.
- `shiftlock` out 1: latched Shift-Lock state, for an LED.

## Operation
- Key state is a `key[15:0][5:0]` register array, 1 = pressed.
- Keymap is a synchronous ROM, 512×8, file `cbm2_keymap.mif`.
  - Address is `{ps2_key[8], ps2_key[7:0]}`.
  - Data is `{valid, row[2:0], col[3:0]}`.
  - `valid=0` means the code is ignored; a `row` value > 5 is also ignored.
- Mandatory map entries:
  - 0x1C ('A') → col 2, row 1.
  - 0x12 (L-Shift) → col 8, row 4.
  - 0x58 (Caps Lock) → col 1, row 3 (Shift-Lock position).
  - 0x29 (Space) → col 4, row 0.
- FSM states: IDLE → LOOKUP → APPLY → IDLE.
  - IDLE: when `ps2_key[10] != last_tgl`, latch `last_tgl`, the press bit, and the ROM address, then go to LOOKUP.
  - LOOKUP: ROM data becomes valid; go to APPLY.
  - APPLY: update the matrix per the hold rules below; go to IDLE.
- The toggle is sampled only in IDLE. Events arrive far more slowly than 3 cycles apart, so none are lost.
- Hold logic uses one hold slot: `hold_key` (col,row), a 20-bit `hold_cnt`, and a `rel_pending` flag.
  - Press of K: if `rel_pending`, clear `hold_key` first. Then set `key[K]=1`, `hold_key=K`, `hold_cnt=HOLD_CYCLES`, `rel_pending=0`.
  - Release of K with `K==hold_key` and `hold_cnt!=0`: set `rel_pending=1`; the key stays pressed.
  - Release of any other key, or after the counter has expired: clear `key[K]` immediately.
  - `hold_cnt` decrements every cycle while nonzero. When it reaches 0 with `rel_pending=1`, clear `key[hold_key]` and `rel_pending` on that same cycle.
  - Simultaneous expiry and APPLY: expiry is processed first, then the APPLY action.
- Row output:
  - `row_n[r]` is registered as `~|{key[c][r]}` over all c with `col_n[c]==0`.
  - Multiple selected columns are OR'ed.
  - With no column selected, `row_n = 6'h3F`.
- Reset effects:
  - Clears `key`, `hold_cnt`, `rel_pending`, and `shiftlock`.
  - Sets `row_n=6'h3F`.
  - Loads `last_tgl` from `ps2_key[10]` so that no spurious event fires.
  - Puts the FSM in IDLE.
  - A reset mid-FSM abandons the event.

## Timing
- Toggle change seen at the IDLE edge N. ROM data is valid at N+1. The matrix updates at edge N+2.
- `row_n` reflects a new matrix state at edge N+3; end-to-end latency is 3 cycles.
- A `col_n` change is reflected on `row_n` after 1 cycle.
- Release deferral:
  - A key pressed at APPLY edge P stays set until edge P+`HOLD_CYCLES`, if its release arrived earlier.
  - A release arriving later than that clears the key at its own APPLY edge.

## Configuration
- `CBM2_SHIFTLOCK_EN` defined:
  - A press of code 0x58 toggles `shiftlock` and drives `key[1][3]` from `shiftlock`.
  - Releases of 0x58 are ignored, and the hold logic is bypassed for this code.
- Undefined:
  - 0x58 is a normal momentary key through the keymap, subject to the hold rules.
  - `shiftlock` is tied to 0.

## Test plan
- Reset with `ps2_key=11'h400`, `col_n=16'hFFFF`: `row_n=6'h3F` and `shiftlock=0`; holding the toggle steady produces no event.
- Press 0x1C, then `col_n=16'hFFFB`: `row_n=6'h3D` on the 3rd cycle after the toggle. `col_n=16'hFFF7` gives 6'h3F.
- Press then release 0x1C 100 cycles apart, with `HOLD_CYCLES=1000`: col 2 reads 6'h3D until 1000 cycles after the press APPLY, then 6'h3F.
- Hold 0x1C and 0x12 (L-Shift), select columns 2 and 8 (`col_n=16'hFEFB`): `row_n=6'h2D`. Release 0x12 after hold expiry: 6'h3D after 3 cycles.
- Press 0x1C, release it within the hold window, then press 0x29 before expiry: at the 0x29 APPLY edge, col 2 clears and col 4 row 0 sets (`col_n=16'hFFEF` gives 6'h3E).
- With `CBM2_SHIFTLOCK_EN`: press/release/press 0x58 toggles `shiftlock` 0→1→0, and col 1 row 3 follows it. Without the macro: 0x58 acts momentary subject to hold, and `shiftlock` stays 0.
